// File: rtl/div_pkg.sv
// Shared definitions for the RV32M divide unit: widths, op encoding, FSM states
// and small operand helpers.
package div_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 6;
    localparam logic [CNT_W-1:0] LAST_ITER = 6'd31;

    // Encoding matches funct3[1:0] of the RV32M divide group.
    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    function automatic logic op_signed(input op_e op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic op_is_rem(input op_e op);
        return (op == REM) || (op == REMU);
    endfunction

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                  input logic is_signed);
        return (is_signed && v[XLEN-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep or restore.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    assign shifted = {rem, dvd_bit};
    // One extra bit beyond the 33-bit partial remainder carries the sign.
    assign diff    = {1'b0, shifted} - {2'b00, divisor};
    assign q_bit   = ~diff[WIDTH+1];

    // The kept difference is always below the divisor, so it fits in WIDTH bits.
    assign rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit RV32M divider: one quotient bit per cycle, with divide-by-zero
// and signed overflow resolved without iterating.
module div_unit #(
    parameter int XLEN = div_pkg::XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    import div_pkg::*;

    state_e           state_q, state_d;
    logic             accept;
    logic             pending;
    op_e              op_q;
    logic [XLEN-1:0]  a_q, b_q;
    logic [XLEN-1:0]  dvd_q, dvs_q, rem_q;
    logic             quo_neg, rem_neg;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  result_q;

    logic             sgn_op, by_zero, overflow, special;
    logic [XLEN-1:0]  special_result, final_result, quo_final;
    logic [XLEN-1:0]  rem_next;
    logic             q_bit;

    assign sgn_op   = op_signed(op_q);
    assign by_zero  = (b_q == '0);
    assign overflow = sgn_op && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
    assign special  = by_zero || overflow;

    div_step #(.WIDTH(XLEN)) u_step (
        .rem      (rem_q),
        .dvd_bit  (dvd_q[XLEN-1]),
        .divisor  (dvs_q),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    assign quo_final = {dvd_q[XLEN-2:0], q_bit};

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned
        // and no latch is inferred.
        special_result = '0;
        final_result   = '0;
        if (by_zero)
            special_result = op_is_rem(op_q) ? a_q : '1;
        else
            special_result = op_is_rem(op_q) ? '0 : a_q;
        if (op_is_rem(op_q))
            final_result = rem_neg ? -rem_next : rem_next;
        else
            final_result = quo_neg ? -quo_final : quo_final;
    end

    // Next state and Moore outputs. The cycle after acceptance is a prep cycle in
    // IDLE: operands are already latched, so special cases are decided from them.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending)
                    state_d = special ? DONE : RUN;
                else if (start)
                    accept = 1'b1;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt_q == LAST_ITER)
                    state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending  <= 1'b0;
            op_q     <= DIV;
            a_q      <= '0;
            b_q      <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            quo_neg  <= 1'b0;
            rem_neg  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                pending <= 1'b1;
                op_q    <= op_e'(op);
                a_q     <= a;
                b_q     <= b;
            end

            if (state_q == IDLE && pending) begin
                pending <= 1'b0;
                if (special) begin
                    result_q <= special_result;
                end else begin
                    dvd_q   <= magnitude(a_q, sgn_op);
                    dvs_q   <= magnitude(b_q, sgn_op);
                    rem_q   <= '0;
                    cnt_q   <= '0;
                    quo_neg <= sgn_op && (a_q[XLEN-1] ^ b_q[XLEN-1]);
                    rem_neg <= sgn_op && a_q[XLEN-1];
                end
            end

            if (state_q == RUN) begin
                dvd_q <= {dvd_q[XLEN-2:0], q_bit};
                rem_q <= rem_next;
                cnt_q <= cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER)
                    result_q <= final_result;
            end
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vectors, control-flow sequences and
// randomized operations against an arithmetic reference model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] result;

    int pass_cnt  = 0;
    int total_cnt = 0;

    div_unit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", name, got, exp);
        else
            pass_cnt++;
    endtask

    // Reference: RISC-V M-extension rules in plain integer arithmetic.
    function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] x,
                                               input logic [31:0] y);
        logic is_sgn;
        logic want_rem;
        int   sx, sy;
        is_sgn   = (o == 2'b00) || (o == 2'b10);
        want_rem = (o == 2'b10) || (o == 2'b11);
        sx = x;
        sy = y;
        if (y == 32'd0)
            return want_rem ? x : 32'hFFFF_FFFF;
        if (is_sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
            return want_rem ? 32'd0 : 32'h8000_0000;
        if (is_sgn)
            return want_rem ? 32'(sx % sy) : 32'(sx / sy);
        return want_rem ? (x % y) : (x / y);
    endfunction

    function automatic int ref_latency(input logic [1:0] o, input logic [31:0] x,
                                       input logic [31:0] y);
        logic is_sgn;
        is_sgn = (o == 2'b00) || (o == 2'b10);
        if (y == 32'd0 || (is_sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))
            return 1;
        return 33;
    endfunction

    // Issue one op from IDLE; returns result, edges from accept to done, busy cycles.
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] res, output int lat, output int busy_cnt);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start    = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) busy_cnt++;
            if (done) break;
        end
        res = result;
        if (!done) begin
            check("done_timeout", 32'(lat), 32'd0);
        end else begin
            @(posedge clk);
            #1;
            check("done_width", {31'd0, done}, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] res;
        int          lat, busy_cnt, pulses, width_bad, cyc, done_seen;
        int          t[3];
        logic        prev_done;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        vecs[0]  = '{2'b01, 32'd100,       32'd7,         32'd14,        33};
        vecs[1]  = '{2'b11, 32'd100,       32'd7,         32'd2,         33};
        vecs[2]  = '{2'b00, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33};
        vecs[3]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};
        vecs[4]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         33};
        vecs[5]  = '{2'b01, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
        vecs[6]  = '{2'b11, 32'd5,         32'd0,         32'd5,         1};
        vecs[7]  = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[8]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
        vecs[9]  = '{2'b01, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33};
        vecs[10] = '{2'b00, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
        vecs[11] = '{2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1};
        vecs[12] = '{2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33};
        vecs[13] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33};

        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",   {31'd0, busy}, 32'd0);
        check("reset_done",   {31'd0, done}, 32'd0);
        check("reset_result", result,        32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, busy_cnt);
            check($sformatf("vec%0d_result", i),  res,          vecs[i].res);
            check($sformatf("vec%0d_latency", i), 32'(lat),     32'(vecs[i].lat));
            check($sformatf("vec%0d_busy", i),    32'(busy_cnt), (vecs[i].lat == 1) ? 32'd0 : 32'd32);
        end

        // Second start mid-RUN is ignored; operand changes after accept have no effect.
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd100; b = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 5) begin start = 1'b1; a = 32'd1000; b = 32'd3; end
            if (lat == 6) start = 1'b0;
            if (lat == 10) a = 32'd55;
            if (done) break;
        end
        check("ignore_start_result",  result,   32'd14);
        check("ignore_start_latency", 32'(lat), 32'd33);
        @(posedge clk);
        #1;

        // Reset at RUN cycle 10 aborts without a done pulse.
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd100; b = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy",   {31'd0, busy}, 32'd0);
        check("abort_done",   {31'd0, done}, 32'd0);
        check("abort_result", result,        32'd0);
        reset = 1'b0;
        done_seen = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 32'd0);

        // Back-to-back with start held high: accept on every IDLE cycle after DONE.
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd100; b = 32'd7;
        pulses = 0; width_bad = 0; cyc = 0; prev_done = 1'b0;
        while (cyc < 200 && pulses < 3) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) begin
                if (prev_done) width_bad++;
                else begin
                    t[pulses] = cyc;
                    check($sformatf("b2b_result%0d", pulses), result, 32'd14);
                    pulses++;
                end
            end
            prev_done = done;
        end
        start = 1'b0;
        check("b2b_pulses", 32'(pulses), 32'd3);
        if (pulses == 3) begin
            check("b2b_first",   32'(t[0]),        32'd34);
            check("b2b_period1", 32'(t[1] - t[0]), 32'd35);
            check("b2b_period2", 32'(t[2] - t[1]), 32'd35);
        end
        @(posedge clk);
        #1;
        if (done) width_bad++;
        check("b2b_width", 32'(width_bad), 32'd0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                3: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                4: ra = 32'($urandom_range(0, 50));
                default: ;
            endcase
            do_op(ro, ra, rb, res, lat, busy_cnt);
            check($sformatf("rand%0d_op%0d_%h_%h", i, ro, ra, rb), res, ref_result(ro, ra, rb));
            check($sformatf("rand%0d_latency", i), 32'(lat), 32'(ref_latency(ro, ra, rb)));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter: XLEN, 32, operand/result width in bits; only 32 is supported.
REQ-002 Port: clk  input  1  rising-edge clock; the block has one clock.
REQ-003 Port: reset  input  1  reset; synchronous and active-high.
REQ-004 Port: start  input  1  request pulse; sampled only in IDLE.
REQ-005 Port: op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU (equals funct3[1:0] of the RV32M divide group).
REQ-006 Port: a  input  XLEN  dividend.
REQ-007 Port: b  input  XLEN  divisor.
REQ-008 Port: busy  output  1  high while in RUN.
REQ-009 Port: done  output  1  one-cycle pulse; result valid.
REQ-010 Port: result  output  XLEN  quotient or remainder selected by op.

Function
REQ-011 The block SHALL use FSM states IDLE, RUN and DONE.
REQ-012 In IDLE, start=1 at an edge SHALL latch op, a and b; later changes on those inputs SHALL have no effect on the operation in flight.
REQ-013 start SHALL be ignored in RUN and DONE; there is no queueing.
REQ-014 Normal case: accepted at edge N, state SHALL be RUN with busy=1 for edges N+1..N+32 (32 iterations), and done=1 for exactly the cycle after edge N+33.
REQ-015 Divide-by-zero (b=0) SHALL skip RUN: transition IDLE->DONE, with done asserted the cycle after edge N+1.
REQ-016 Divide-by-zero result: DIV/DIVU SHALL return 0xFFFFFFFF; REM/REMU SHALL return a.
REQ-017 Signed overflow (op DIV or REM, a=0x80000000, b=0xFFFFFFFF) SHALL skip RUN: DIV returns 0x80000000, REM returns 0, done timing per REQ-015.
REQ-018 Iteration SHALL be restoring, one quotient bit per cycle, MSB first: shift {rem,dividend} left by one, trial-subtract the divisor from the 33-bit partial remainder, keep the difference if it is non-negative and set the quotient bit to 1; otherwise restore and set the bit to 0.
REQ-019 Signed ops SHALL divide absolute values; quotient negated iff sign(a)!=sign(b); remainder takes the sign of a. This gives truncation toward zero.
REQ-020 DONE SHALL return to IDLE after one cycle; busy=0 in IDLE and DONE.
REQ-021 result SHALL hold its last value from DONE onward until the next completion.
REQ-022 result SHALL equal the new value in the same cycle that done=1.
REQ-023 A start in the IDLE cycle immediately after DONE SHALL be accepted normally.

Reset
REQ-024 reset=1 at an edge SHALL force state=IDLE, busy=0, done=0, result=0 and clear the internal registers, regardless of state, including mid-RUN.
REQ-025 reset SHALL take priority over start at the same edge.
REQ-026 An aborted operation SHALL never produce a done pulse.

Structure
REQ-027 A shared package div_pkg SHALL hold XLEN, the op encoding as an enum (DIV, DIVU, REM, REMU) and the FSM state enum.
REQ-028 The per-iteration shift/trial-subtract/select datapath SHALL be one sub-module, div_step: combinational, taking remainder, dividend bit and divisor, and producing the next remainder and the quotient bit.
REQ-029 The FSM, iteration counter (6-bit, counts 0..31), operand/sign latches and final sign fix-up SHALL live in div_unit.

Verification
REQ-030 DIVU a=100 b=7 -> done exactly 33 cycles after the accepting edge, result=14; REMU same operands -> result=2.
REQ-031 DIV a=0xFFFFFFF9 (-7) b=2 -> result=0xFFFFFFFD (-3); REM same -> result=0xFFFFFFFF (-1); REM a=7 b=0xFFFFFFFE -> result=1.
REQ-032 DIVU a=5 b=0 -> result=0xFFFFFFFF, done 1 cycle after accept, busy never high; REMU a=5 b=0 -> result=5.
REQ-033 DIV a=0x80000000 b=0xFFFFFFFF -> result=0x80000000; REM same -> result=0; DIVU a=0xFFFFFFFF b=1 -> result=0xFFFFFFFF after full 33 cycles.
REQ-034 Start DIVU 100/7, pulse start with new operands at RUN cycle 5, then change a at RUN cycle 10 -> the second start is ignored and result=14; in a second run, reset at RUN cycle 10 -> next cycle busy=0, done=0, result=0, and no done pulse follows.
REQ-035 Back-to-back operations, start held high continuously -> a new accept on each IDLE cycle after DONE, with each done pulse exactly one cycle wide.
